// File: rtl/dwt_lift53_stream.sv
// dwt_lift53_stream: streaming single-level LeGall 5/3 lifting DWT, one (low,high) pair per two samples,
// whole-sample symmetric extension at both line ends.
module dwt_lift53_stream #(
    parameter int DATA_W    = 8,
    parameter int LINE_LEN  = 16,
    parameter int SIGNED_IN = 1,
    localparam int OUT_W    = DATA_W + 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    line_clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_low,
    output logic signed [OUT_W-1:0] out_high,
    output logic                    out_last,
    output logic                    busy
);
    localparam int IW = $clog2(LINE_LEN);

    typedef enum logic [1:0] {S_FIRST, S_ODD, S_EVEN} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic signed [OUT_W-1:0] x_in, x_even, x_odd, d_prev, odd_v, next_v, d, dm1, s;
    logic signed [OUT_W:0] t;
    logic in_fire, out_fire, last, emit;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last     = idx == IW'(LINE_LEN - 1);
    assign busy     = (idx != '0) || out_valid;
    assign x_in     = {{(OUT_W-DATA_W){(SIGNED_IN != 0) && in_data[DATA_W-1]}}, in_data};

    // In S_ODD only the final pair is produced, with x[LINE_LEN] mirrored onto x[LINE_LEN-2]
    always_comb begin
        state_nx = state;
        if (line_clr)
            state_nx = S_FIRST;
        else if (in_fire)
            state_nx = (state == S_ODD) ? (last ? S_FIRST : S_EVEN) : S_ODD;
        emit   = in_fire && (state == S_EVEN || (state == S_ODD && last));
        odd_v  = (state == S_ODD) ? x_in : x_odd;
        next_v = (state == S_ODD) ? x_even : x_in;
        d      = odd_v - ((x_even + next_v) >>> 1);
        dm1    = (state == S_EVEN && idx == IW'(2)) ? d : d_prev;
        // one guard bit: d[n-1]+d[n]+2 can reach 512 for unsigned input
        t      = {dm1[OUT_W-1], dm1} + {d[OUT_W-1], d} + (OUT_W+1)'(2);
        s      = OUT_W'(x_even + (t >>> 2));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            state <= S_FIRST;
        else
            state <= state_nx;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx       <= '0;
            x_even    <= '0;
            x_odd     <= '0;
            d_prev    <= '0;
            out_valid <= 1'b0;
            out_low   <= '0;
            out_high  <= '0;
            out_last  <= 1'b0;
        end else if (line_clr) begin
            idx       <= '0;
            d_prev    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_fire)
                out_valid <= 1'b0;
            if (in_fire) begin
                idx <= last ? '0 : idx + IW'(1);
                if (state != S_ODD)
                    x_even <= x_in;
                if (state == S_ODD)
                    x_odd <= x_in;
                if (state == S_EVEN)
                    d_prev <= d;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_low   <= s;
                out_high  <= d;
                out_last  <= state == S_ODD;
            end
        end
    end
endmodule
